// File: rtl/temp_bcd_conv.sv
// temp_bcd_conv: DS18B20 raw temperature to sign/range flags and 5-digit BCD hundredths of a degree
module temp_bcd_conv #(
  parameter logic [15:0] OVR_POS_LIMIT = 16'd2000,
  parameter logic [15:0] OVR_NEG_LIMIT = 16'd880
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] raw_temp,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic        ovr,
  output logic [19:0] bcd_data
);
  typedef enum logic [1:0] {IDLE, ABS, SCALE, CONV} state_t;
  state_t state, state_n;
  logic [15:0] raw_r, mag16, prod;
  logic [10:0] mag;
  logic        sign_r, ovr_r, fin;
  logic [13:0] hund, hund_n;
  logic [19:0] bcd, bcd_adj, bcd_n;
  logic [33:0] sh;
  logic [3:0]  cnt;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE)  ? (start ? ABS : IDLE) :
              (state == ABS)   ? SCALE :
              (state == SCALE) ? CONV :
              (cnt == 4'd13)   ? IDLE : CONV;
  end
  always_comb begin
    busy = state != IDLE;
    fin  = state == CONV && cnt == 4'd13;
  end
  // 0x8000 negates to itself; saturation below folds it to 2047
  assign mag16 = raw_r[15] ? ~raw_r + 16'd1 : raw_r;
  assign prod  = {5'd0, mag} * 16'd25;
  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign sh     = {bcd_adj, hund} << 1;
  assign bcd_n  = sh[33:14];
  assign hund_n = sh[13:0];
  always_ff @(posedge clk)
    if (!rst_n) begin
      raw_r    <= '0;
      mag      <= '0;
      sign_r   <= 1'b0;
      ovr_r    <= 1'b0;
      hund     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      sign     <= 1'b0;
      ovr      <= 1'b0;
      bcd_data <= '0;
    end else begin
      done <= fin;
      if (state == IDLE && start) raw_r <= raw_temp;
      if (state == ABS) begin
        sign_r <= raw_r[15];
        ovr_r  <= raw_r[15] ? mag16 > OVR_NEG_LIMIT : mag16 > OVR_POS_LIMIT;
        mag    <= mag16 > 16'd2047 ? 11'd2047 : mag16[10:0];
      end
      if (state == SCALE) begin
        hund <= prod[15:2];
        bcd  <= '0;
        cnt  <= '0;
      end
      if (state == CONV) begin
        bcd  <= bcd_n;
        hund <= hund_n;
        cnt  <= cnt + 4'd1;
      end
      if (fin) begin
        bcd_data <= bcd_n;
        sign     <= sign_r;
        ovr      <= ovr_r;
      end
    end
endmodule

// File: doc/temp_bcd_conv.md
Name: temp_bcd_conv

Overview:
- Sits between the DS18B20 bus controller and the segment display controller.
- Takes the 16-bit raw two's-complement scratchpad temperature (12-bit resolution, LSB = 0.0625 °C).
- Produces a sign flag, a range flag and a 5-digit packed-BCD value in hundredths of a degree (XXX.XX), ready for digit-wise display.
- Conversion is iterative: abs, scale ×25/4, then a 14-step shift-add-3 (double-dabble) sequence.

Parameters:
- OVR_POS_LIMIT, 2000: largest legal positive magnitude in raw LSBs (125.00 °C).
- OVR_NEG_LIMIT, 880: largest legal negative magnitude in raw LSBs (-55.00 °C).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to convert raw_temp; sampled only in IDLE.
- raw_temp  input  16  DS18B20 raw temperature, two's complement, LSB = 1/16 °C.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse when the outputs below are updated.
- sign  output  1  1 = negative temperature.
- ovr  output  1  1 = raw value outside the legal range.
- bcd_data  output  20  {hundreds, tens, units, tenths, hundredths}, 4 bits each.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, sign=0, ovr=0, bcd_data=0.
  - Reset mid-conversion aborts the conversion with no done pulse; outputs clear to 0.
- States: IDLE -> ABS -> SCALE -> CONV -> IDLE.
- IDLE:
  - When start=1 at edge N: capture raw_temp and go to ABS.
  - start is ignored in every other state; it is not queued.
  - A level-held start retriggers each time IDLE is re-entered.
- ABS (edge N+1):
  - sign_r = raw[15]; mag = raw[15] ? (~raw + 1) : raw, 16 bits.
  - ovr_r = (!sign_r && mag > OVR_POS_LIMIT) || (sign_r && mag > OVR_NEG_LIMIT).
  - mag is saturated to 2047 if larger. raw 0x8000 gives mag 0x8000, which saturates to 2047.
- SCALE (edge N+2):
  - hund = (mag*25) >> 2, truncated, 14 bits, max 12793.
  - Load the 20-bit BCD accumulator with 0 and a 4-bit iteration counter with 0.
- CONV (edges N+3..N+16, 14 cycles), per cycle:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, hund} shifts left by 1.
  - The counter increments; at counter = 13 the state goes to IDLE.
- Output update (edge N+16, the exit from CONV):
  - bcd_data, sign, ovr are written; done=1 for the following cycle only.
  - Outputs hold until the next completed conversion or reset.
- Timing:
  - busy is 1 in the cycles after edges N..N+15 and 0 after edge N+16.
  - Latency: start-sampling edge to done-asserting edge is 16 cycles.
  - Minimum start spacing is 17 cycles; a start sampled at edge N+17 is accepted.
- Zero and rounding:
  - raw=0 gives sign=0.
  - A negative value whose truncated magnitude is 0 does not exist at 1/16 resolution (min 0.06).
  - sign is reported exactly as raw[15].
- Range: ovr does not suppress conversion; the saturated magnitude is still converted.

Test Plan:
- Reset, then idle 5 cycles -> bcd_data=0x00000, sign=0, ovr=0, busy=0, done never pulses.
- start with raw=0x0191 (+25.0625) -> done exactly 16 cycles after the sampling edge; bcd_data=0x02506, sign=0, ovr=0.
- raw=0xFC90 (-55) -> bcd_data=0x05500, sign=1, ovr=0; then raw=0xFFF8 (-0.5) -> 0x00050, sign=1.
- raw=0x07D0 (+125) -> 0x12500, ovr=0; raw=0x0550 (85) -> 0x08500; raw=0x07FF -> 0x12793, ovr=1; raw=0xFC80 (-56) -> 0x05600, sign=1, ovr=1.
- start held high continuously -> conversions complete every 17 cycles; a start pulse at busy=1 with a different raw is ignored and the result matches the first raw.
- rst_n low for 1 cycle mid-CONV (edge N+8) -> no done, outputs 0, busy=0; a next start with raw=0x0008 converts normally to 0x00050.
